// File: rtl/mem_burst_master_pkg.sv
// Shared memory-port definitions for the 256x16 burst master.
// Word geometry, rw polarity, FSM state encoding and command bundle.
package mas8_mem_pkg;

    localparam int MEM_DW = 16;
    localparam int MEM_AW = 8;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD       = 2'd2,
        S_RD_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic              rw;
        logic [MEM_AW-1:0] addr;
        logic [MEM_AW-1:0] len;
    } burst_cmd_t;

endpackage

// File: rtl/mem_burst_master_if.sv
// Bundle of the command, write, read and memory-port signals.
// master: the burst engine; slave: the CPU side plus the memory.
interface mem_burst_master_if
    import mas8_mem_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;

    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;

    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;

    logic          done;

    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len,
        input  wdata, wvalid, rready, mem_dout,
        output cmd_ready, wready, rdata, rvalid, done,
        output mem_en, mem_rw, mem_addr, mem_din
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len,
        output wdata, wvalid, rready, mem_dout,
        input  cmd_ready, wready, rdata, rvalid, done,
        input  mem_en, mem_rw, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for the 256x16 memory port.
// One command at a time; streams write beats in or read beats out.
module mem_burst_master
    import mas8_mem_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW
) (
    input  logic  clk,
    input  logic  rstz,
    mem_burst_master_if.master bus,
    inout  wire   dvdd,
    inout  wire   dgnd
);

    wire unused_pwr = dvdd ^ dgnd;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          done_q, done_d;

    logic          cmd_ready;
    logic          wready;
    logic          mem_en;
    logic          mem_rw;
    logic [DW-1:0] mem_din;
    logic          issue;
    logic          last;
    burst_cmd_t    cmd;

    assign cmd  = '{rw: bus.cmd_rw, addr: bus.cmd_addr, len: bus.cmd_len};
    assign last = (cnt_q == '0);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        wready    = 1'b0;
        mem_en    = 1'b0;
        mem_rw    = MEM_RD;
        mem_din   = '0;
        issue     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_d  = cmd.addr;
                    cnt_d   = cmd.len;
                    state_d = (cmd.rw == MEM_RD) ? S_RD : S_WR;
                end
            end
            S_WR: begin
                wready  = 1'b1;
                mem_en  = bus.wvalid;
                mem_rw  = MEM_WR;
                mem_din = bus.wdata;
                if (bus.wvalid) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                // Only fetch when the output register is free or being drained.
                issue  = !rvalid_q || bus.rready;
                mem_en = issue;
                if (issue) begin
                    rdata_d  = bus.mem_dout;
                    rvalid_d = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (last) state_d = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                if (rvalid_q && bus.rready) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wready    = wready;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.done      = done_q;
    assign bus.mem_en    = mem_en;
    assign bus.mem_rw    = mem_rw;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = mem_din;

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural 256x16 memory plus a
// reference word array updated from the intended bursts.
module tb_mem_burst_master;
    import mas8_mem_pkg::*;

    logic clk = 1'b0;
    logic rstz;
    wire  dvdd = 1'b1;
    wire  dgnd = 1'b0;

    mem_burst_master_if #(.DW(16), .AW(8)) bus ();

    mem_burst_master dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus),
        .dvdd (dvdd),
        .dgnd (dgnd)
    );

    always #5 clk = ~clk;

    logic [15:0] tmem    [256];
    logic [15:0] ref_mem [256];
    logic        mem_init;
    int          n_writes;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 16'h5A5A);
    endfunction

    assign bus.mem_dout = tmem[bus.mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tmem[i] <= init_val(i);
            n_writes <= 0;
        end else if (bus.mem_en && bus.mem_rw == MEM_WR) begin
            tmem[bus.mem_addr] <= bus.mem_din;
            n_writes <= n_writes + 1;
        end
    end

    task automatic send_cmd(input logic rw, input logic [7:0] a,
                            input logic [7:0] l);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready got %b want 1", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_len   = 8'($urandom);
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] l,
                               input bit gaps, input bit rnd,
                               input logic [15:0] base);
        int beats, i, cyc, w0;
        logic wv;
        logic [15:0] d;
        beats = int'(l) + 1;
        i = 0;
        cyc = 0;
        send_cmd(MEM_WR, a, l);
        w0 = n_writes;
        while (i < beats && cyc < 4 * beats + 20) begin
            @(negedge clk);
            cyc++;
            wv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d  = rnd ? 16'($urandom) : base + 16'(i);
            bus.wvalid = wv;
            bus.wdata  = d;
            #1;
            checks++;
            if (bus.mem_en !== wv || bus.wready !== 1'b1) begin
                errors++;
                $display("FAIL wr_strobe en=%b wready=%b want en=%b wready=1",
                         bus.mem_en, bus.wready, wv);
            end
            if (wv) begin
                checks++;
                if (bus.mem_addr !== 8'(int'(a) + i) || bus.mem_din !== d) begin
                    errors++;
                    $display("FAIL wr_beat addr=%h din=%h want addr=%h din=%h",
                             bus.mem_addr, bus.mem_din, 8'(int'(a) + i), d);
                end
                ref_mem[8'(int'(a) + i)] = d;
                i++;
            end
        end
        if (i < beats) begin
            errors++;
            $display("FAIL wr_timeout beats=%0d want %0d", i, beats);
        end
        @(negedge clk);
        bus.wvalid = 1'b1;
        bus.wdata  = 16'hDEAD;
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1 ||
            bus.mem_en !== 1'b0 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL wr_done done=%b rdy=%b en=%b wready=%b want 1 1 0 0",
                     bus.done, bus.cmd_ready, bus.mem_en, bus.wready);
        end
        checks++;
        if (n_writes - w0 !== beats) begin
            errors++;
            $display("FAIL wr_count got %0d want %0d", n_writes - w0, beats);
        end
        @(negedge clk);
        bus.wvalid = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL wr_done_pulse done=%b want 0", bus.done);
        end
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [7:0] l,
                              input int mode);
        int beats, k, c, first;
        logic rr;
        logic [15:0] exp_d;
        beats = int'(l) + 1;
        k = 0;
        c = 0;
        first = -1;
        send_cmd(MEM_RD, a, l);
        while (k < beats && c < 6 * beats + 20) begin
            @(negedge clk);
            rr = (mode == 0) ? 1'b1 :
                 (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            bus.rready = rr;
            #1;
            if (bus.rvalid && first < 0) first = c;
            if (bus.rvalid && !rr) begin
                checks++;
                if (bus.mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_stall_en en=%b want 0", bus.mem_en);
                end
            end
            if (bus.rvalid && rr) begin
                exp_d = ref_mem[8'(int'(a) + k)];
                checks++;
                if (bus.rdata !== exp_d) begin
                    errors++;
                    $display("FAIL rd_beat %0d got %h want %h", k, bus.rdata, exp_d);
                end
                k++;
            end
            c++;
        end
        if (k < beats) begin
            errors++;
            $display("FAIL rd_timeout beats=%0d want %0d", k, beats);
        end
        checks++;
        if (first !== 1) begin
            errors++;
            $display("FAIL rd_latency first=%0d want 1", first);
        end
        if (mode == 0) begin
            checks++;
            if (c !== beats + 1) begin
                errors++;
                $display("FAIL rd_throughput cycles=%0d want %0d", c, beats + 1);
            end
        end
        @(negedge clk);
        bus.rready = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_done done=%b rdy=%b rvalid=%b want 1 1 0",
                     bus.done, bus.cmd_ready, bus.rvalid);
        end
    endtask

    task automatic test_reset;
        rstz = 1'b0;
        mem_init = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.wvalid = 1'b0;
        bus.wdata = '0;
        bus.rready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.wready !== 1'b0 || bus.mem_en !== 1'b0 ||
            bus.mem_rw !== 1'b1 || bus.mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl rdy=%b wr=%b en=%b rw=%b addr=%h want 1 0 0 1 00",
                     bus.cmd_ready, bus.wready, bus.mem_en, bus.mem_rw, bus.mem_addr);
        end
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 16'h0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd rvalid=%b rdata=%h done=%b want 0 0000 0",
                     bus.rvalid, bus.rdata, bus.done);
        end
        @(negedge clk);
        rstz = 1'b1;
        mem_init = 1'b0;
    endtask

    task automatic test_basic;
        write_burst(8'h10, 8'd3, 1'b0, 1'b0, 16'hA001);
        read_burst(8'h10, 8'd3, 0);
    endtask

    task automatic test_wrap;
        write_burst(8'hFE, 8'd3, 1'b0, 1'b1, 16'h0);
        read_burst(8'hFE, 8'd3, 0);
    endtask

    task automatic test_read_throttle;
        read_burst(8'hFC, 8'd7, 1);
        read_burst(8'h30, 8'd7, 2);
    endtask

    task automatic test_write_gaps;
        write_burst(8'h60, 8'd12, 1'b1, 1'b1, 16'h0);
        read_burst(8'h60, 8'd12, 2);
    endtask

    task automatic test_reset_mid_read;
        int k, c;
        write_burst(8'h40, 8'd7, 1'b0, 1'b1, 16'h0);
        send_cmd(MEM_RD, 8'h40, 8'd7);
        k = 0;
        c = 0;
        while (k < 2 && c < 20) begin
            @(negedge clk);
            bus.rready = 1'b1;
            #1;
            if (bus.rvalid) begin
                checks++;
                if (bus.rdata !== ref_mem[8'h40 + 8'(k)]) begin
                    errors++;
                    $display("FAIL rst_rd_beat got %h want %h",
                             bus.rdata, ref_mem[8'h40 + 8'(k)]);
                end
                k++;
            end
            c++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (bus.mem_en !== 1'b1 || bus.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre en=%b rvalid=%b want 1 1", bus.mem_en, bus.rvalid);
        end
        rstz = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_async rvalid=%b rdy=%b en=%b want 0 1 0",
                     bus.rvalid, bus.cmd_ready, bus.mem_en);
        end
        @(negedge clk);
        rstz = 1'b1;
        bus.rready = 1'b0;
        read_burst(8'h40, 8'd7, 0);
    endtask

    task automatic test_full_burst;
        int bad;
        write_burst(8'h80, 8'hFF, 1'b0, 1'b1, 16'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (tmem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_burst bad_words=%0d want 0", bad);
        end
        read_burst(8'h00, 8'hFF, 0);
    endtask

    task automatic test_random;
        logic [7:0] a, l;
        for (int n = 0; n < 4; n++) begin
            a = 8'($urandom);
            l = 8'($urandom_range(0, 31));
            write_burst(a, l, 1'b1, 1'b1, 16'h0);
            read_burst(a, l, 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_read_throttle();
        test_write_gaps();
        test_reset_mid_read();
        test_full_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
